// File: rtl/ecp5_seq_pkg.sv
// Shared definitions for the TRELLIS_FF init sequencer: state encoding and counter sizing.
package ecp5_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    ENABLE    = 3'd4,
    RUN       = 3'd5
  } seq_state_e;

  // Counter must hold the largest dwell value; all dwells count 0..N-1.
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ff_init_sequencer_sync2.sv
// Two-flop synchroniser with async active-low clear; used for the PLL LOCK input.
module ff_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ff_init_sequencer.sv
// Sequences LSR/SP of TRELLIS_FF banks after a filtered PLL lock, with a
// 4-phase software re-init handshake. All outputs are registered.
module ff_init_sequencer
  import ecp5_seq_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int LOCK_CYCLES = 16,
  parameter int LSR_CYCLES  = 8,
  parameter int STAGGER     = 2,
  parameter int CE_DELAY    = 4
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               LOCK,
  input  logic               REINIT_REQ,
  output logic               REINIT_ACK,
  output logic [NUM_DOM-1:0] LSR,
  output logic [NUM_DOM-1:0] SP,
  output logic               READY,
  output logic [2:0]         STATE
);

  localparam int CW = cnt_w(LOCK_CYCLES, LSR_CYCLES, STAGGER, CE_DELAY);
  localparam int DW = $clog2(NUM_DOM + 1);

  logic               lock_s;
  seq_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [DW-1:0]      dom_q;
  logic               pending_q, ack_q, ready_q;
  logic [NUM_DOM-1:0] lsr_q, sp_q;

  ff_sync2 u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .d_i    (LOCK),
    .q_o    (lock_s)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      dom_q     <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      lsr_q     <= '1;
      sp_q      <= '0;
    end else begin
      if (ack_q && !REINIT_REQ) ack_q <= 1'b0;

      if (state_q != WAIT_LOCK && !lock_s) begin
        // Lock loss beats everything; a request coinciding with it in RUN is kept.
        state_q <= WAIT_LOCK;
        cnt_q   <= '0;
        dom_q   <= '0;
        ready_q <= 1'b0;
        lsr_q   <= '1;
        sp_q    <= '0;
        if (state_q == RUN && REINIT_REQ && !ack_q) pending_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        case (state_q)
          WAIT_LOCK: begin
            cnt_q <= '0;
            if (lock_s) state_q <= FILTER;
          end
          FILTER: begin
            if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
              state_q <= HOLD;
              cnt_q   <= '0;
            end
          end
          HOLD: begin
            if (cnt_q == CW'(LSR_CYCLES - 1)) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
              dom_q   <= '0;
            end
          end
          RELEASE: begin
            if (cnt_q == CW'(STAGGER - 1)) begin
              cnt_q <= '0;
              dom_q <= dom_q + DW'(1);
              for (int i = 0; i < NUM_DOM; i++)
                if (dom_q == DW'(i)) lsr_q[i] <= 1'b0;
              if (dom_q == DW'(NUM_DOM - 1)) state_q <= ENABLE;
            end
          end
          ENABLE: begin
            if (cnt_q == CW'(CE_DELAY - 1)) begin
              state_q <= RUN;
              cnt_q   <= '0;
              sp_q    <= '1;
              ready_q <= 1'b1;
              if (pending_q) begin
                ack_q     <= 1'b1;
                pending_q <= 1'b0;
              end
            end
          end
          RUN: begin
            cnt_q <= '0;
            if (REINIT_REQ && !ack_q) begin
              state_q   <= HOLD;
              ready_q   <= 1'b0;
              lsr_q     <= '1;
              sp_q      <= '0;
              pending_q <= 1'b1;
            end
          end
          default: begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            lsr_q   <= '1;
            sp_q    <= '0;
          end
        endcase
      end
    end
  end

  assign REINIT_ACK = ack_q;
  assign LSR        = lsr_q;
  assign SP         = sp_q;
  assign READY      = ready_q;
  assign STATE      = state_q;

endmodule
